// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the receive-only and transmit-only UARTs
// in the 7.37 MHz domain.
//   t_uartrxonly_state    receiver FSM state encoding (3 bits)
//   c_uart_os_rate        oversample ticks per bit
//   c_uart_sample_lo/hi   first/last oversample index used for bit voting
//   c_uart_clk_div_115200 system clocks per oversample tick at 115200 baud
//   f_majority3           2-of-3 vote
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } t_uartrxonly_state;

    localparam int unsigned c_uart_os_rate        = 16;
    localparam int unsigned c_uart_sample_lo      = 7;
    localparam int unsigned c_uart_sample_hi      = 9;
    localparam int unsigned c_uart_clk_div_115200 = 4;

    function automatic logic f_majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_only_ce_div.sv
// clock_enable_divider: emits a one-clock enable every par_ce_divisor
// qualified input enables.
//   i_clk     clock
//   i_rst     synchronous active-high reset
//   i_ce_mhz  input enable; the divider only advances while it is high
//   o_ce      registered one-clock enable pulse
module clock_enable_divider #(
    parameter int unsigned par_ce_divisor = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ce_mhz,
    output logic o_ce
);

    localparam int unsigned c_w = (par_ce_divisor > 1) ? $clog2(par_ce_divisor) : 1;
    localparam logic [c_w-1:0] c_last = c_w'(par_ce_divisor - 1);

    logic [c_w-1:0] cnt_q, cnt_d;
    logic           ce_q, ce_d;

    always_comb begin
        cnt_d = cnt_q;
        ce_d  = 1'b0;
        if (i_ce_mhz) begin
            if (cnt_q == c_last) begin
                cnt_d = '0;
                ce_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign o_ce = ce_q;

endmodule

// File: rtl/uart_rx_only.sv
// uart_rx_only: 8N1 receive-only UART with 16x oversampling, 3-sample
// majority voting, framing-error pulse and sticky overrun flag.
//   BAUD            line rate; 4*115200/BAUD must be an integer
//   i_clk_7_37mhz   clock
//   i_rst_7_37mhz   synchronous active-high reset
//   ei_uart_rx      asynchronous serial line, idles high
//   o_rx_data       received byte, stable while o_rx_valid is high
//   o_rx_valid      byte available, held until accepted
//   i_rx_ready      consumer accepts on o_rx_valid && i_rx_ready
//   o_rx_frame_err  one-clock pulse when a stop bit is sampled low
//   o_rx_overrun    sticky; a byte was dropped because the last one was unread
module uart_rx_only
    import uart_pkg::*;
#(
    parameter int unsigned BAUD = 115200
) (
    input  logic       i_clk_7_37mhz,
    input  logic       i_rst_7_37mhz,
    input  logic       ei_uart_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_rx_frame_err,
    output logic       o_rx_overrun
);

    localparam int unsigned c_divisor = c_uart_clk_div_115200 * 115200 / BAUD;
    localparam logic [3:0]  c_os_lo   = 4'(c_uart_sample_lo);
    localparam logic [3:0]  c_os_mid  = 4'(c_uart_sample_lo + 1);
    localparam logic [3:0]  c_os_hi   = 4'(c_uart_sample_hi);
    localparam logic [3:0]  c_os_last = 4'(c_uart_os_rate - 1);

    logic s_ce_16x;
    logic s_rx_sync;

    logic              rx_meta_q, rx_sync_q;
    t_uartrxonly_state state_q, state_d;
    logic [3:0]        os_q, os_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [1:0]        smp_q, smp_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              fe_q, fe_d;
    logic              ov_q, ov_d;
    logic              maj;
    logic              deliver;
    logic              accept;

    clock_enable_divider #(
        .par_ce_divisor(c_divisor)
    ) u_ce_div (
        .i_clk    (i_clk_7_37mhz),
        .i_rst    (i_rst_7_37mhz),
        .i_ce_mhz (1'b1),
        .o_ce     (s_ce_16x)
    );

    always_ff @(posedge i_clk_7_37mhz) begin
        if (i_rst_7_37mhz) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= ei_uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign s_rx_sync = rx_sync_q;

    // Third vote is the live sample on the os=9 tick, so no third register.
    assign maj    = f_majority3(smp_q[0], smp_q[1], s_rx_sync);
    assign accept = valid_q & i_rx_ready;

    always_comb begin
        state_d   = state_q;
        os_d      = os_q;
        bit_idx_d = bit_idx_q;
        smp_d     = smp_q;
        shreg_d   = shreg_q;
        fe_d      = 1'b0;
        deliver   = 1'b0;

        if (s_ce_16x) begin
            os_d = os_q + 1'b1;
            if (os_q == c_os_lo)  smp_d[0] = s_rx_sync;
            if (os_q == c_os_mid) smp_d[1] = s_rx_sync;

            case (state_q)
                ST_IDLE: begin
                    // os is held at 0 so ST_START begins its bit at os=0.
                    os_d = '0;
                    if (!s_rx_sync) state_d = ST_START;
                end
                ST_START: begin
                    if (os_q == c_os_hi && maj) begin
                        state_d = ST_IDLE;
                        os_d    = '0;
                    end else if (os_q == c_os_last) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end
                end
                ST_DATA: begin
                    if (os_q == c_os_hi) shreg_d = {maj, shreg_q[7:1]};
                    if (os_q == c_os_last) begin
                        if (bit_idx_q == 3'd7) state_d = ST_STOP;
                        else                   bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (os_q == c_os_hi) begin
                        os_d = '0;
                        if (maj) begin
                            // Leave mid stop bit so the next start edge is caught.
                            deliver = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    os_d = '0;
                    if (s_rx_sync) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    os_d    = '0;
                end
            endcase
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ov_d    = ov_q;
        if (deliver) begin
            if (!valid_q || accept) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk_7_37mhz) begin
        if (i_rst_7_37mhz) begin
            state_q   <= ST_IDLE;
            os_q      <= '0;
            bit_idx_q <= '0;
            smp_q     <= '1;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_q      <= os_d;
            bit_idx_q <= bit_idx_d;
            smp_q     <= smp_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    assign o_rx_data      = data_q;
    assign o_rx_valid     = valid_q;
    assign o_rx_frame_err = fe_q;
    assign o_rx_overrun   = ov_q;

endmodule
